// File: rtl/hbridge_gate_driver_if.sv
// Pin bundle between the motorcontrol command side and the dual H-bridge gate driver.
// The master drives enable, direction commands and duty; the slave returns the bridge pins.
interface hbridge_gate_driver_if #(
  parameter int PWM_W = 8
);
  logic             en;
  logic             hbridge1a;
  logic             hbridge2a;
  logic             hbridge1b;
  logic             hbridge2b;
  logic [PWM_W-1:0] duty;
  logic             out1a;
  logic             out2a;
  logic             out1b;
  logic             out2b;
  logic             dead_a;
  logic             dead_b;
  logic             pwm_wrap;

  modport master (
    output en, hbridge1a, hbridge2a, hbridge1b, hbridge2b, duty,
    input  out1a, out2a, out1b, out2b, dead_a, dead_b, pwm_wrap
  );

  modport slave (
    input  en, hbridge1a, hbridge2a, hbridge1b, hbridge2b, duty,
    output out1a, out2a, out1b, out2b, dead_a, dead_b, pwm_wrap
  );
endinterface

// File: rtl/hbridge_gate_driver.sv
// Two-channel H-bridge gate driver: shared PWM, per-channel direction FSM that
// inserts a fixed dead time before every drive state, and a global coast enable.
module hbridge_gate_driver #(
  parameter int PWM_W    = 8,
  parameter int DEAD_CYC = 16
) (
  input logic                clk,
  input logic                rst,
  hbridge_gate_driver_if.slave bus
);

  typedef enum logic [2:0] {
    ST_COAST,
    ST_FWD,
    ST_REV,
    ST_BRAKE,
    ST_DEAD
  } state_e;

  localparam logic [7:0]       DCNT_LOAD = 8'(DEAD_CYC - 1);
  localparam logic [PWM_W-1:0] CNT_MAX   = '1;

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] duty_q;
  logic             wrap_q;
  logic             pwmOn;

  state_e     state_q  [2];
  state_e     state_d  [2];
  state_e     target_q [2];
  state_e     target_d [2];
  state_e     cmdSt    [2];
  logic [7:0] dcnt_q   [2];
  logic [7:0] dcnt_d   [2];
  logic [1:0] pins_q   [2];
  logic       dead_q   [2];

  function automatic state_e decodeCmd(input logic [1:0] c);
    case (c)
      2'b10:   decodeCmd = ST_FWD;
      2'b01:   decodeCmd = ST_REV;
      2'b11:   decodeCmd = ST_BRAKE;
      default: decodeCmd = ST_COAST;
    endcase
  endfunction

  function automatic logic [1:0] pinsFor(input state_e s, input logic on);
    case (s)
      ST_FWD:   pinsFor = {on, 1'b0};
      ST_REV:   pinsFor = {1'b0, on};
      ST_BRAKE: pinsFor = 2'b11;
      default:  pinsFor = 2'b00;
    endcase
  endfunction

  assign pwmOn = (cnt_q < duty_q);

  // Dropping enable looks exactly like a coast command on both channels.
  always_comb begin
    cmdSt[0] = decodeCmd(bus.en ? {bus.hbridge1a, bus.hbridge2a} : 2'b00);
    cmdSt[1] = decodeCmd(bus.en ? {bus.hbridge1b, bus.hbridge2b} : 2'b00);
  end

  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      state_d[ch]  = state_q[ch];
      target_d[ch] = target_q[ch];
      dcnt_d[ch]   = dcnt_q[ch];
      if (cmdSt[ch] == ST_COAST) begin
        state_d[ch] = ST_COAST;
      end else if (state_q[ch] == ST_DEAD) begin
        // A new non-coast target restarts the full dead interval.
        if (cmdSt[ch] != target_q[ch]) begin
          target_d[ch] = cmdSt[ch];
          dcnt_d[ch]   = DCNT_LOAD;
        end else if (dcnt_q[ch] == 8'd0) begin
          state_d[ch] = target_q[ch];
        end else begin
          dcnt_d[ch] = dcnt_q[ch] - 8'd1;
        end
      end else if (cmdSt[ch] != state_q[ch]) begin
        state_d[ch]  = ST_DEAD;
        target_d[ch] = cmdSt[ch];
        dcnt_d[ch]   = DCNT_LOAD;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      wrap_q <= 1'b0;
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch]  <= ST_COAST;
        target_q[ch] <= ST_COAST;
        dcnt_q[ch]   <= 8'd0;
        pins_q[ch]   <= 2'b00;
        dead_q[ch]   <= 1'b0;
      end
    end else begin
      cnt_q  <= cnt_q + PWM_W'(1);
      wrap_q <= (cnt_q == CNT_MAX);
      // Duty only changes at the period boundary so a period is never split.
      if (cnt_q == CNT_MAX) begin
        duty_q <= bus.duty;
      end
      for (int ch = 0; ch < 2; ch++) begin
        state_q[ch]  <= state_d[ch];
        target_q[ch] <= target_d[ch];
        dcnt_q[ch]   <= dcnt_d[ch];
        pins_q[ch]   <= pinsFor(state_q[ch], pwmOn);
        dead_q[ch]   <= (state_q[ch] == ST_DEAD);
      end
    end
  end

  assign bus.out1a    = pins_q[0][1];
  assign bus.out2a    = pins_q[0][0];
  assign bus.out1b    = pins_q[1][1];
  assign bus.out2b    = pins_q[1][0];
  assign bus.dead_a   = dead_q[0];
  assign bus.dead_b   = dead_q[1];
  assign bus.pwm_wrap = wrap_q;

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Scoreboard bench for hbridge_gate_driver: stimulus pushes hand-computed expectations
// tagged with a cycle index; a negedge monitor pops and compares them.
module tb_hbridge_gate_driver;

  typedef struct {
    int         tk;
    logic [6:0] mask;
    logic [6:0] val;
    string      name;
  } exp_t;

  // Observation vector bit groups: {out1a,out2a,out1b,out2b,dead_a,dead_b,pwm_wrap}
  localparam logic [6:0] MA  = 7'b1100000;
  localparam logic [6:0] MB  = 7'b0011000;
  localparam logic [6:0] DA  = 7'b0000100;
  localparam logic [6:0] DB  = 7'b0000010;
  localparam logic [6:0] PW  = 7'b0000001;
  localparam logic [6:0] ALL = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tk  = -4;
  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  exp_t curExp;
  logic [6:0] obs;

  hbridge_gate_driver_if #(.PWM_W(8)) bus ();

  hbridge_gate_driver #(
    .PWM_W    (8),
    .DEAD_CYC (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // tk is the PWM counter value seen at each negedge once reset is released at tk 0.
  always @(posedge clk) tk <= tk + 1;

  assign obs = {bus.out1a, bus.out2a, bus.out1b, bus.out2b, bus.dead_a, bus.dead_b, bus.pwm_wrap};

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].tk <= tk) begin
      curExp = sbq.pop_front();
      total  = total + 1;
      if (curExp.tk < tk) begin
        bad = bad + 1;
        $display("[TB] FAIL %s stale check tk=%0d now=%0d", curExp.name, curExp.tk, tk);
      end else if ((obs & curExp.mask) !== (curExp.val & curExp.mask)) begin
        bad = bad + 1;
        $display("[TB] FAIL %s tk=%0d got=%b expected=%b mask=%b",
                 curExp.name, tk, obs & curExp.mask, curExp.val & curExp.mask, curExp.mask);
      end
    end
  end

  task automatic checkOutput(input int t, input logic [6:0] m, input logic [6:0] v, input string nm);
    exp_t e;
    e.tk   = t;
    e.mask = m;
    e.val  = v;
    e.name = nm;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input int t, input logic e, input logic [1:0] a,
                               input logic [1:0] b, input logic [7:0] d);
    while (tk < t) @(negedge clk);
    bus.en        = e;
    bus.hbridge1a = a[1];
    bus.hbridge2a = a[0];
    bus.hbridge1b = b[1];
    bus.hbridge2b = b[0];
    bus.duty      = d;
  endtask

  initial begin
    bus.en        = 1'b1;
    bus.hbridge1a = 1'b1;
    bus.hbridge2a = 1'b0;
    bus.hbridge1b = 1'b0;
    bus.hbridge2b = 1'b0;
    bus.duty      = 8'd128;

    // Reset held with A commanding FWD: everything must stay low.
    checkOutput(-3, ALL, 7'b0, "reset_m3");
    checkOutput(-2, ALL, 7'b0, "reset_m2");
    checkOutput(-1, ALL, 7'b0, "reset_m1");
    while (tk < 0) @(negedge clk);
    rst = 1'b0;

    // Coast to FWD: 16 cycles of dead, duty 128 only takes effect after first wrap.
    checkOutput(1,   DA,      7'b0000000, "fwd_dead_before");
    checkOutput(2,   DA,      7'b0000100, "fwd_dead_start");
    checkOutput(17,  DA,      7'b0000100, "fwd_dead_last");
    checkOutput(18,  MA | DA, 7'b0000000, "fwd_dead_end");
    checkOutput(255, PW,      7'b0000000, "wrap_low");
    checkOutput(256, PW | MA, 7'b0000001, "wrap_pulse");
    checkOutput(257, PW | MA, 7'b1000000, "fwd_pwm_first_on");
    checkOutput(384, MA,      7'b1000000, "fwd_pwm_last_on");
    checkOutput(385, MA,      7'b0000000, "fwd_pwm_first_off");
    checkOutput(512, MA,      7'b0000000, "fwd_pwm_last_off");
    checkOutput(513, MA,      7'b1000000, "fwd_pwm_next_on");

    // FWD -> REV reversal goes through a full dead interval.
    applyStimulus(520, 1'b1, 2'b01, 2'b00, 8'd128);
    checkOutput(521, MA,      7'b1000000, "rev_still_fwd");
    checkOutput(522, MA | DA, 7'b0000100, "rev_dead_start");
    checkOutput(537, MA | DA, 7'b0000100, "rev_dead_last");
    checkOutput(538, MA | DA, 7'b0100000, "rev_drive");

    // Coast aborts a dead interval; retarget mid-dead restarts it.
    applyStimulus(600, 1'b1, 2'b10, 2'b00, 8'd128);
    checkOutput(601, MA,      7'b0100000, "abort_prev_rev");
    checkOutput(602, MA | DA, 7'b0000100, "abort_dead");
    applyStimulus(605, 1'b1, 2'b00, 2'b00, 8'd128);
    checkOutput(606, DA,      7'b0000100, "abort_dead_hold");
    checkOutput(607, MA | DA, 7'b0000000, "abort_coast");
    checkOutput(620, MA | DA, 7'b0000000, "abort_coast_stay");
    applyStimulus(630, 1'b1, 2'b10, 2'b00, 8'd128);
    checkOutput(632, DA,      7'b0000100, "retgt_dead");
    applyStimulus(638, 1'b1, 2'b01, 2'b00, 8'd128);
    checkOutput(640, MA | DA, 7'b0000100, "retgt_no_drive");
    checkOutput(650, DA,      7'b0000100, "retgt_reload");
    checkOutput(655, DA,      7'b0000100, "retgt_dead_last");
    checkOutput(656, MA | DA, 7'b0000000, "retgt_dead_end");
    checkOutput(769, MA,      7'b0100000, "retgt_rev_on");
    checkOutput(896, MA,      7'b0100000, "retgt_rev_last_on");
    checkOutput(897, MA,      7'b0000000, "retgt_rev_off");

    // Duty changes land only at the next wrap; duty 0 never drives.
    applyStimulus(900, 1'b1, 2'b01, 2'b00, 8'd64);
    checkOutput(1024, PW,      7'b0000001, "duty64_wrap");
    checkOutput(1025, MA,      7'b0100000, "duty64_first");
    applyStimulus(1050, 1'b1, 2'b01, 2'b00, 8'd192);
    checkOutput(1088, MA,      7'b0100000, "duty64_last_on");
    checkOutput(1089, MA,      7'b0000000, "duty64_kept");
    checkOutput(1280, PW | MA, 7'b0000001, "duty192_wrap");
    checkOutput(1281, MA,      7'b0100000, "duty192_first");
    checkOutput(1472, MA,      7'b0100000, "duty192_last_on");
    checkOutput(1473, MA,      7'b0000000, "duty192_off");
    applyStimulus(1500, 1'b1, 2'b01, 2'b00, 8'd0);
    checkOutput(1537, MA,      7'b0000000, "duty0_start");
    checkOutput(1600, MA,      7'b0000000, "duty0_mid");
    checkOutput(1792, MA,      7'b0000000, "duty0_end");

    // B brake after dead time, then enable drop coasts both channels.
    applyStimulus(1800, 1'b1, 2'b01, 2'b11, 8'd255);
    checkOutput(1801, MB,      7'b0000000, "brake_coast");
    checkOutput(1802, DB,      7'b0000010, "brake_dead_start");
    checkOutput(1817, MB | DB, 7'b0000010, "brake_dead_last");
    checkOutput(1818, MB | DB, 7'b0011000, "brake_on");
    applyStimulus(1830, 1'b0, 2'b01, 2'b11, 8'd255);
    checkOutput(1831, MB,                7'b0011000, "en_fall_hold");
    checkOutput(1832, MA | MB | DA | DB, 7'b0000000, "en_fall_coast");

    // Both channels leave coast together; B retargets so its dead time runs longer.
    applyStimulus(1850, 1'b1, 2'b01, 2'b11, 8'd255);
    checkOutput(1852, DA | DB, 7'b0000110, "par_dead_both");
    applyStimulus(1860, 1'b1, 2'b01, 2'b10, 8'd255);
    checkOutput(1867, DA | DB,      7'b0000110, "par_a_dead_last");
    checkOutput(1868, DA | DB,      7'b0000010, "par_a_done");
    checkOutput(1877, DB,           7'b0000010, "par_b_dead_last");
    checkOutput(1878, DB,           7'b0000000, "par_b_done");
    checkOutput(2049, MA | MB,      7'b0110000, "duty255_on");
    checkOutput(2304, MA | MB | PW, 7'b0000001, "duty255_off_slot");
    checkOutput(2305, MA | MB,      7'b0110000, "duty255_on_again");

    while (sbq.size() != 0 && tk < 2320) @(negedge clk);
    while (sbq.size() != 0) begin
      curExp = sbq.pop_front();
      total  = total + 1;
      bad    = bad + 1;
      $display("[TB] FAIL %s never checked tk=%0d now=%0d", curExp.name, curExp.tk, tk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
